// File: rtl/wb_commit_unit.sv
// ============================================================================
// wb_commit_unit
// ----------------------------------------------------------------------------
// Write-back end of the MEM/WB pipeline register. Commits wb_* signals to the
// architectural state (GPR file, HI/LO, LLbit). It also serves the two
// decode-stage GPR read ports and counts committed write events.
//
// Ports
//   clk              rising-edge clock
//   rst              asynchronous reset, active-low (0 = reset)
//   wb_wd/wb_wreg/wb_wdata        GPR write address / enable / data
//   wb_hi/wb_lo/wb_whilo          HI/LO write data / joint enable
//   wb_LLbit_we/wb_LLbit_value    LLbit write enable / value
//   flush            exception flush; clears LLbit (wins over wb_LLbit_we)
//   re1/raddr1/rdata1, re2/raddr2/rdata2   combinational GPR read ports
//   hi_o/lo_o/LLbit_o                      current HI / LO / LLbit
//   commit_cnt       committed-write-event counter (wraps silently)
//
// Configuration
//   WB_BYPASS_EN     when defined, enables same-cycle forwarding of the write
//                    being committed onto the read ports, HI/LO and LLbit.
//                    Forwarding is disabled while rst is low.
//                    When undefined, the outputs show stored state only.
// ============================================================================
module wb_commit_unit #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] wb_wd,
    input  logic              wb_wreg,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic [DATA_W-1:0] wb_hi,
    input  logic [DATA_W-1:0] wb_lo,
    input  logic              wb_whilo,
    input  logic              wb_LLbit_we,
    input  logic              wb_LLbit_value,
    input  logic              flush,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              LLbit_o,
    output logic [DATA_W-1:0] commit_cnt
);

    logic [DATA_W-1:0] gpr_r [NUM_REGS];
    logic [DATA_W-1:0] hi_r;
    logic [DATA_W-1:0] lo_r;
    logic              llbit_r;
    logic [DATA_W-1:0] cnt_r;

    logic              gpr_we_s;
    logic              event_s;

    // Writes to r0 are discarded, so they neither modify state nor count.
    assign gpr_we_s = wb_wreg && (wb_wd != {ADDR_W{1'b0}});
    assign event_s  = gpr_we_s || wb_whilo || wb_LLbit_we;

    // GPR file: r0 is cleared on reset and never written afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                gpr_r[i] <= {DATA_W{1'b0}};
            end
        end else if (gpr_we_s) begin
            gpr_r[wb_wd] <= wb_wdata;
        end else begin
            gpr_r[wb_wd] <= gpr_r[wb_wd];
        end
    end

    // HI/LO are always updated as a pair.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_r <= {DATA_W{1'b0}};
            lo_r <= {DATA_W{1'b0}};
        end else if (wb_whilo) begin
            hi_r <= wb_hi;
            lo_r <= wb_lo;
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    // LLbit: flush clears it with priority over a pending LL/SC write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            llbit_r <= 1'b0;
        end else if (flush) begin
            llbit_r <= 1'b0;
        end else if (wb_LLbit_we) begin
            llbit_r <= wb_LLbit_value;
        end else begin
            llbit_r <= llbit_r;
        end
    end

    // Commit counter: one increment per cycle with any effective write; flush does not block it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {DATA_W{1'b0}};
        end else if (event_s) begin
            cnt_r <= cnt_r + {{(DATA_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign commit_cnt = cnt_r;

`ifdef WB_BYPASS_EN
    // Read port 1 with forwarding of the GPR write committing this cycle.
    always_comb begin
        rdata1 = {DATA_W{1'b0}};
        if (re1 && (raddr1 != {ADDR_W{1'b0}})) begin
            if (rst && gpr_we_s && (wb_wd == raddr1)) begin
                rdata1 = wb_wdata;
            end else begin
                rdata1 = gpr_r[raddr1];
            end
        end else begin
            rdata1 = {DATA_W{1'b0}};
        end
    end

    // Read port 2 with forwarding of the GPR write committing this cycle.
    always_comb begin
        rdata2 = {DATA_W{1'b0}};
        if (re2 && (raddr2 != {ADDR_W{1'b0}})) begin
            if (rst && gpr_we_s && (wb_wd == raddr2)) begin
                rdata2 = wb_wdata;
            end else begin
                rdata2 = gpr_r[raddr2];
            end
        end else begin
            rdata2 = {DATA_W{1'b0}};
        end
    end

    // HI/LO and LLbit outputs with forwarding of this cycle's update.
    always_comb begin
        hi_o    = hi_r;
        lo_o    = lo_r;
        LLbit_o = llbit_r;
        if (rst && wb_whilo) begin
            hi_o = wb_hi;
            lo_o = wb_lo;
        end else begin
            hi_o = hi_r;
            lo_o = lo_r;
        end
        if (!rst) begin
            LLbit_o = llbit_r;
        end else if (flush) begin
            LLbit_o = 1'b0;
        end else if (wb_LLbit_we) begin
            LLbit_o = wb_LLbit_value;
        end else begin
            LLbit_o = llbit_r;
        end
    end
`else
    // Read port 1: stored state only.
    always_comb begin
        rdata1 = {DATA_W{1'b0}};
        if (re1 && (raddr1 != {ADDR_W{1'b0}})) begin
            rdata1 = gpr_r[raddr1];
        end else begin
            rdata1 = {DATA_W{1'b0}};
        end
    end

    // Read port 2: stored state only.
    always_comb begin
        rdata2 = {DATA_W{1'b0}};
        if (re2 && (raddr2 != {ADDR_W{1'b0}})) begin
            rdata2 = gpr_r[raddr2];
        end else begin
            rdata2 = {DATA_W{1'b0}};
        end
    end

    // HI/LO and LLbit outputs: stored state only.
    always_comb begin
        hi_o    = hi_r;
        lo_o    = lo_r;
        LLbit_o = llbit_r;
    end
`endif

endmodule
